operand_deserializer: RTL and testbench
=======================================

# operand_deserializer

Serial-in, parallel-out front end of the FP adder datapath. Shifts two single-precision operands (A then B, each LSB first) in over a one-bit serial link and presents them in parallel to the adder core. It holds both operands stable until the core acknowledges them, then re-arms for the next pair. Bit order and handshake style mirror the serial output stage at the far end of the datapath.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; count register is clog2(WIDTH) bits wide.

Ports:
- clk_in  input  1  clock; all logic on rising edge.
- rst_in  input  1  reset: one clock; reset is synchronous and active-low.
- serial_in  input  1  data bit; sampled only on accepted beats.
- serial_valid_in  input  1  bit strobe. A beat is accepted at an edge where serial_valid_in=1 and input_rdy=1.
- abort_in  input  1  synchronous abort; discards any partial frame.
- take_in  input  1  adder core consumes the operand pair; honoured only while operands_valid=1.
- input_rdy  output  1  registered; 1 while a bit can be accepted.
- operands_valid  output  1  registered; 1 while operand_a and operand_b hold a complete pair.
- loading_b  output  1  registered; 1 while the B operand is being shifted in.
- operand_a  output  WIDTH  operand A, registered.
- operand_b  output  WIDTH  operand B, registered.

## Operation
States:
- LOAD_A
- LOAD_B
- HOLD

Reset (rst_in=0 at an edge):
- State goes to LOAD_A and count to 0.
- operand_a=0, operand_b=0.
- input_rdy=1, operands_valid=0, loading_b=0.

Shifting:
- On an accepted beat, the target register shifts right one place and serial_in enters bit WIDTH-1. After WIDTH beats, the first bit received is in bit 0 (LSB first).
- count increments on each accepted beat.

LOAD_A:
- The beat with count=WIDTH-1 loads the last bit of A.
- At that edge: count goes to 0, state goes to LOAD_B, and loading_b goes to 1.

LOAD_B:
- The beat with count=WIDTH-1 loads the last bit of B.
- At that edge: count goes to 0, state goes to HOLD, operands_valid goes to 1, input_rdy goes to 0, and loading_b goes to 0.

HOLD:
- serial_valid_in is ignored, and operands stay stable.
- When take_in=1: state goes to LOAD_A, operands_valid goes to 0, and input_rdy goes to 1.
- operand_a and operand_b keep their values until they are shifted over.

Abort:
- abort_in=1 in LOAD_A or LOAD_B sends the block to LOAD_A with count=0 and loading_b=0.
- Operand registers are not cleared.
- A beat presented in the same cycle as abort is dropped.

Priority: reset > abort > take / beat.

Boundaries:
- abort_in in HOLD discards the held pair: operands_valid goes to 0 and state goes to LOAD_A.
- take_in outside HOLD has no effect.
- take_in and abort_in together in HOLD: abort wins. The result is identical (LOAD_A), and no take is counted.
- Reset mid-frame discards everything.
- count never exceeds WIDTH-1.

## Timing
- input_rdy, operands_valid and loading_b are pure state decodes, registered with the state.
- Minimum latency: with serial_valid_in held at 1, operands_valid rises at the edge of the 2·WIDTH-th accepted beat (64 cycles from the first beat for WIDTH=32).
- HOLD exit: take_in sampled at edge T. In the following cycle operands_valid=0 and input_rdy=1, so the first bit of the next A can be accepted at edge T+1.
- Throughput: 2·WIDTH+1 cycles per pair at best.
- No combinational path from any input to any output.

## Structure
Shared package fp_adder_pkg holds:
- WIDTH default (32)
- state encodings LOAD_A=2'd0, LOAD_B=2'd1, HOLD=2'd2, shared with other FP adder stages

One sub-module is natural: shift_in_reg (WIDTH-bit right-shift register with a shift enable). It is instantiated twice, for A and B, and the top-level FSM gates each instance's enable.

## Test plan
1. Reset with rst_in=0 for 2 cycles → input_rdy=1, operands_valid=0, loading_b=0, operands=0.
2. Stream A=0x3F800000 then B=0x40000000 LSB first, valid every cycle → loading_b rises after beat 32; operands_valid rises after beat 64 with operand_a=0x3F800000 and operand_b=0x40000000; input_rdy=0.
3. In HOLD, toggle serial_valid_in/serial_in for 10 cycles → operands unchanged. Then take_in=1 for one cycle → next cycle operands_valid=0, input_rdy=1, and a new bit is accepted at the next edge.
4. Gapped strobe (valid every 3rd cycle) for A=0xDEADBEEF, B=0x00000001 → same final values; operands_valid rises exactly at the 64th accepted beat.
5. After 40 beats (into B), assert abort_in with a valid beat in the same cycle → state LOAD_A, count=0, beat dropped. A subsequent clean 64-beat frame yields the correct pair.
6. rst_in=0 during HOLD with take_in=1 → all outputs return to their reset values; no take observed.

Source files
------------

// File: rtl/fp_adder_pkg.sv
// -----------------------------------------------------------------------------
// fp_adder_pkg
// Definitions shared by the FP adder datapath stages.
//   FP_WIDTH     : default operand width (single precision)
//   fsm_state_t  : frame-level state encoding (LOAD_A / LOAD_B / HOLD), also
//                  used by the serial output stage at the far end of the datapath
// -----------------------------------------------------------------------------
package fp_adder_pkg;

    localparam int FP_WIDTH = 32;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } fsm_state_t;

endpackage : fp_adder_pkg

// File: rtl/operand_deserializer_shift_in_reg.sv
// -----------------------------------------------------------------------------
// shift_in_reg
// WIDTH-bit right-shift register, LSB-first serial load. Each enabled edge
// moves the contents one place toward bit 0 and puts i_bit into bit WIDTH-1,
// so after WIDTH shifts the first bit received sits in bit 0.
// Ports:
//   clk_in      : clock, rising edge
//   rst_in      : synchronous active-low reset, clears the register
//   i_shift_en  : shift enable
//   i_bit       : serial data bit
//   o_data      : register contents
// -----------------------------------------------------------------------------
module shift_in_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             i_shift_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_data <= '0;
        end else if (i_shift_en) begin
            r_data <= {i_bit, r_data[WIDTH-1:1]};
        end
    end

    assign o_data = r_data;

endmodule : shift_in_reg

// File: rtl/operand_deserializer.sv
// -----------------------------------------------------------------------------
// operand_deserializer
// Serial-in, parallel-out front end of the FP adder. Receives operand A then
// operand B (each LSB first) over a one-bit strobed link, then holds the pair
// until the adder core takes it.
// Ports:
//   clk_in           : clock, rising edge
//   rst_in           : synchronous active-low reset
//   serial_in        : serial data bit
//   serial_valid_in  : bit strobe; beat accepted when input_rdy is also 1
//   abort_in         : drops the current frame (or held pair), back to LOAD_A
//   take_in          : core consumes the pair; only honoured in HOLD
//   input_rdy        : 1 while a bit can be accepted (LOAD_A / LOAD_B)
//   operands_valid   : 1 while operand_a / operand_b hold a complete pair
//   loading_b        : 1 while operand B is being shifted in
//   operand_a/_b     : parallel operands
// -----------------------------------------------------------------------------
module operand_deserializer
    import fp_adder_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             serial_in,
    input  logic             serial_valid_in,
    input  logic             abort_in,
    input  logic             take_in,
    output logic             input_rdy,
    output logic             operands_valid,
    output logic             loading_b,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

    fsm_state_t    r_state;
    logic [CW-1:0] r_count;
    logic          r_input_rdy;
    logic          r_operands_valid;
    logic          r_loading_b;

    logic w_beat;
    logic w_shift_a;
    logic w_shift_b;

    // A beat coinciding with abort is dropped, so abort masks the shift enables.
    assign w_beat    = serial_valid_in & r_input_rdy & ~abort_in;
    assign w_shift_a = w_beat & (r_state == LOAD_A);
    assign w_shift_b = w_beat & (r_state == LOAD_B);

    shift_in_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_shift_en (w_shift_a),
        .i_bit      (serial_in),
        .o_data     (operand_a)
    );

    shift_in_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_shift_en (w_shift_b),
        .i_bit      (serial_in),
        .o_data     (operand_b)
    );

    // Status outputs are updated alongside the state so each is a registered
    // decode of it, with no input-to-output combinational path.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state          <= LOAD_A;
            r_count          <= '0;
            r_input_rdy      <= 1'b1;
            r_operands_valid <= 1'b0;
            r_loading_b      <= 1'b0;
        end else if (abort_in) begin
            // Also discards a held pair; wins over a simultaneous take.
            r_state          <= LOAD_A;
            r_count          <= '0;
            r_input_rdy      <= 1'b1;
            r_operands_valid <= 1'b0;
            r_loading_b      <= 1'b0;
        end else begin
            case (r_state)
                LOAD_A: begin
                    if (w_beat) begin
                        if (r_count == LAST_BEAT) begin
                            r_count     <= '0;
                            r_state     <= LOAD_B;
                            r_loading_b <= 1'b1;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (w_beat) begin
                        if (r_count == LAST_BEAT) begin
                            r_count          <= '0;
                            r_state          <= HOLD;
                            r_operands_valid <= 1'b1;
                            r_input_rdy      <= 1'b0;
                            r_loading_b      <= 1'b0;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (take_in) begin
                        r_state          <= LOAD_A;
                        r_operands_valid <= 1'b0;
                        r_input_rdy      <= 1'b1;
                    end
                end
                default: begin
                    r_state          <= LOAD_A;
                    r_count          <= '0;
                    r_input_rdy      <= 1'b1;
                    r_operands_valid <= 1'b0;
                    r_loading_b      <= 1'b0;
                end
            endcase
        end
    end

    assign input_rdy      = r_input_rdy;
    assign operands_valid = r_operands_valid;
    assign loading_b      = r_loading_b;

endmodule : operand_deserializer

// File: tb/tb_operand_deserializer.sv
// -----------------------------------------------------------------------------
// tb_operand_deserializer
// Directed bench for operand_deserializer (WIDTH=32). Inputs change on the
// falling edge; outputs are checked on the falling edge after the rising edge
// that consumed them.
// -----------------------------------------------------------------------------
module tb_operand_deserializer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        serial_in;
    logic        serial_valid_in;
    logic        abort_in;
    logic        take_in;
    logic        input_rdy;
    logic        operands_valid;
    logic        loading_b;
    logic [31:0] operand_a;
    logic [31:0] operand_b;

    int n_checks = 0;
    int n_fail   = 0;

    operand_deserializer #(.WIDTH(32)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .abort_in        (abort_in),
        .take_in         (take_in),
        .input_rdy       (input_rdy),
        .operands_valid  (operands_valid),
        .loading_b       (loading_b),
        .operand_a       (operand_a),
        .operand_b       (operand_b)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    // One accepted beat followed by 'gap' idle cycles.
    task automatic beat(input logic b, input int gap);
        serial_valid_in = 1'b1;
        serial_in       = b;
        tick();
        serial_valid_in = 1'b0;
        serial_in       = 1'b0;
        repeat (gap) tick();
    endtask

    // Full A+B frame with boundary checks on loading_b and operands_valid.
    task automatic send_frame(input string tag, input logic [31:0] a,
                              input logic [31:0] b, input int gap);
        logic [63:0] bits;
        bits = {b, a};
        for (int i = 0; i < 64; i++) begin
            serial_valid_in = 1'b1;
            serial_in       = bits[i];
            tick();
            serial_valid_in = 1'b0;
            serial_in       = 1'b0;
            if (i == 30) chk({tag, " loading_b@31"}, {31'd0, loading_b}, 32'd0);
            if (i == 31) chk({tag, " loading_b@32"}, {31'd0, loading_b}, 32'd1);
            if (i == 62) chk({tag, " valid@63"},     {31'd0, operands_valid}, 32'd0);
            if (i == 63) begin
                chk({tag, " valid@64"},     {31'd0, operands_valid}, 32'd1);
                chk({tag, " rdy@64"},       {31'd0, input_rdy}, 32'd0);
                chk({tag, " loading_b@64"}, {31'd0, loading_b}, 32'd0);
            end
            repeat (gap) tick();
        end
        chk({tag, " operand_a"}, operand_a, a);
        chk({tag, " operand_b"}, operand_b, b);
    endtask

    initial begin
        rst_in          = 1'b0;
        serial_in       = 1'b0;
        serial_valid_in = 1'b0;
        abort_in        = 1'b0;
        take_in         = 1'b0;

        // 1. reset
        repeat (2) tick();
        chk("rst input_rdy", {31'd0, input_rdy}, 32'd1);
        chk("rst valid",     {31'd0, operands_valid}, 32'd0);
        chk("rst loading_b", {31'd0, loading_b}, 32'd0);
        chk("rst operand_a", operand_a, 32'd0);
        chk("rst operand_b", operand_b, 32'd0);
        rst_in = 1'b1;
        tick();

        // 2. back-to-back frame
        send_frame("t2", 32'h3F80_0000, 32'h4000_0000, 0);

        // 3. strobes ignored in HOLD, then take
        for (int i = 0; i < 10; i++) begin
            serial_valid_in = i[0];
            serial_in       = i[1];
            tick();
        end
        serial_valid_in = 1'b0;
        chk("t3 hold a",     operand_a, 32'h3F80_0000);
        chk("t3 hold b",     operand_b, 32'h4000_0000);
        chk("t3 hold valid", {31'd0, operands_valid}, 32'd1);
        take_in = 1'b1;
        tick();
        take_in = 1'b0;
        chk("t3 take valid", {31'd0, operands_valid}, 32'd0);
        chk("t3 take rdy",   {31'd0, input_rdy}, 32'd1);
        beat(1'b1, 0);
        chk("t3 first bit", operand_a, 32'h9FC0_0000);
        // abort the partial frame; operands are kept
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        chk("t3 abort rdy", {31'd0, input_rdy}, 32'd1);
        chk("t3 abort a",   operand_a, 32'h9FC0_0000);

        // 4. gapped strobe, one beat every 3rd cycle
        send_frame("t4", 32'hDEAD_BEEF, 32'h0000_0001, 2);
        take_in = 1'b1;
        tick();
        take_in = 1'b0;

        // 5. abort 40 beats in, with a beat in the same cycle
        for (int i = 0; i < 32; i++) begin
            logic [31:0] av;
            av = 32'h1234_5678;
            beat(av[i], 0);
        end
        for (int i = 0; i < 8; i++) beat(1'b1, 0);
        chk("t5 b partial", operand_b, 32'hFF00_0000);
        // take outside HOLD does nothing
        take_in         = 1'b1;
        abort_in        = 1'b1;
        serial_valid_in = 1'b1;
        serial_in       = 1'b1;
        tick();
        take_in         = 1'b0;
        abort_in        = 1'b0;
        serial_valid_in = 1'b0;
        serial_in       = 1'b0;
        chk("t5 abort loading_b", {31'd0, loading_b}, 32'd0);
        chk("t5 abort rdy",       {31'd0, input_rdy}, 32'd1);
        chk("t5 beat dropped b",  operand_b, 32'hFF00_0000);
        chk("t5 kept a",          operand_a, 32'h1234_5678);
        send_frame("t5", 32'hC049_0FDB, 32'h3FC0_0000, 0);

        // abort + take together in HOLD: abort wins, pair discarded
        abort_in = 1'b1;
        take_in  = 1'b1;
        tick();
        abort_in = 1'b0;
        take_in  = 1'b0;
        chk("t5 hold abort valid", {31'd0, operands_valid}, 32'd0);
        chk("t5 hold abort rdy",   {31'd0, input_rdy}, 32'd1);

        // 6. reset during HOLD with take asserted
        send_frame("t6", 32'hAAAA_5555, 32'h0F0F_F0F0, 1);
        rst_in  = 1'b0;
        take_in = 1'b1;
        tick();
        rst_in  = 1'b1;
        take_in = 1'b0;
        chk("t6 rst valid",     {31'd0, operands_valid}, 32'd0);
        chk("t6 rst rdy",       {31'd0, input_rdy}, 32'd1);
        chk("t6 rst loading_b", {31'd0, loading_b}, 32'd0);
        chk("t6 rst operand_a", operand_a, 32'd0);
        chk("t6 rst operand_b", operand_b, 32'd0);
        beat(1'b1, 0);
        chk("t6 post-rst bit", operand_a, 32'h8000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule : tb_operand_deserializer
